// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard detection and operand-forwarding control for a 5-stage RISC-V
// pipeline. It also tracks one outstanding operation in a non-pipelined
// multi-cycle unit (MUL/DIV).
//
// Ports
//   clk, rst_n                    clock; asynchronous active-low reset
//   rs_ID/rd_ID/regWrite_ID       operands and destination of the ID instruction
//   branch_ID, mc_ID              ID instruction is a branch / multi-cycle op
//   rs_EX/rd_EX/regWrite_EX       operands and destination of the EX instruction
//   memRead_EX, mc_issue          EX instruction is a load / issues to the MC unit
//   rd_MEM/regWrite_MEM/memRead_MEM, rd_WB/regWrite_WB   later pipeline stages
//   stall                         hold PC and IF/ID, bubble into ID/EX
//   BJSel[i]                      branch operand i taken from the MEM ALU result
//   ExSel[2i+1:2i]                EX operand i: 00 regfile, 01 MEM, 10 WB, 11 MC
//   mc_busy, mc_wb_valid, mc_wb_rd  multi-cycle scoreboard state / completion
//   mc_err                        sticky: issue attempted while busy
//
// Optional macro HAZ_PERF_CNT_EN adds saturating stall_cnt and mc_stall_cnt.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*AW-1:0]  rs_ID,
  input  logic [AW-1:0]          rd_ID,
  input  logic                   regWrite_ID,
  input  logic                   branch_ID,
  input  logic                   mc_ID,
  input  logic [NUM_SRC*AW-1:0]  rs_EX,
  input  logic [AW-1:0]          rd_EX,
  input  logic                   regWrite_EX,
  input  logic                   memRead_EX,
  input  logic                   mc_issue,
  input  logic [AW-1:0]          rd_MEM,
  input  logic [AW-1:0]          rd_WB,
  input  logic                   regWrite_MEM,
  input  logic                   regWrite_WB,
  input  logic                   memRead_MEM,
  output logic                   stall,
  output logic [NUM_SRC-1:0]     BJSel,
  output logic [NUM_SRC*2-1:0]   ExSel,
  output logic                   mc_busy,
  output logic                   mc_wb_valid,
  output logic [AW-1:0]          mc_wb_rd,
  output logic                   mc_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            mc_stall_cnt
`endif
);

  localparam int CW = $clog2(MC_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 1);

  // Register x0 is hard-wired zero, so it never creates a dependency.
  function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic we);
    return we && (a != '0) && (a == b);
  endfunction

  logic          mc_busy_q, mc_busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pending_rd_q, pending_rd_d;
  logic          mc_err_q, mc_err_d;
  logic          mc_accept;

  // Completion is the cycle the counter reaches 1.
  assign mc_wb_valid = mc_busy_q && (cnt_q == CW'(1));
  assign mc_busy     = mc_busy_q;
  assign mc_wb_rd    = pending_rd_q;
  assign mc_err      = mc_err_q;

  // ---------------------------------------------------------------------------
  // Per-operand comparators
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] hit_ex_id, hit_mem_id, hit_pend_id, hit_issue_id;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [AW-1:0] rs_id_i, rs_ex_i;
      assign rs_id_i = rs_ID[gi*AW +: AW];
      assign rs_ex_i = rs_EX[gi*AW +: AW];

      assign ExSel[gi*2 +: 2] =
          match(rd_MEM, rs_ex_i, regWrite_MEM)         ? 2'b01 :
          match(rd_WB,  rs_ex_i, regWrite_WB)          ? 2'b10 :
          (mc_wb_valid && match(mc_wb_rd, rs_ex_i, 1'b1)) ? 2'b11 : 2'b00;

      // A load in MEM has no data yet; that case is covered by the stall instead.
      assign BJSel[gi] = match(rd_MEM, rs_id_i, regWrite_MEM) && !memRead_MEM;

      assign hit_ex_id[gi]    = match(rd_EX, rs_id_i, regWrite_EX);
      assign hit_mem_id[gi]   = match(rd_MEM, rs_id_i, regWrite_MEM);
      assign hit_pend_id[gi]  = match(pending_rd_q, rs_id_i, mc_busy_q);
      assign hit_issue_id[gi] = match(rd_EX, rs_id_i, 1'b1);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stall causes
  // ---------------------------------------------------------------------------
  logic cause_a, cause_b, cause_c, cause_d, cause_e, cause_f, mc_cause;

  assign cause_a = memRead_EX && (|hit_ex_id);
  assign cause_b = branch_ID && (|hit_ex_id);
  assign cause_c = branch_ID && memRead_MEM && (|hit_mem_id);
  // The completion cycle releases dependants: the regfile is written before
  // they read it one cycle later in EX.
  assign cause_d = ((|hit_pend_id) && !mc_wb_valid) || (mc_issue && (|hit_issue_id));
  assign cause_e = regWrite_ID && match(pending_rd_q, rd_ID, mc_busy_q) && !mc_wb_valid;
  assign cause_f = mc_ID && ((mc_busy_q && !mc_wb_valid) || mc_issue);
  assign mc_cause = cause_d || cause_e || cause_f;
  assign stall    = cause_a || cause_b || cause_c || mc_cause;

  // ---------------------------------------------------------------------------
  // Multi-cycle scoreboard
  // ---------------------------------------------------------------------------
  // A new issue is accepted when idle or in the completion cycle (back-to-back).
  assign mc_accept = mc_issue && (!mc_busy_q || mc_wb_valid);

  always_comb begin
    mc_busy_d    = mc_busy_q;
    cnt_d        = cnt_q;
    pending_rd_d = pending_rd_q;
    mc_err_d     = mc_err_q || (mc_issue && mc_busy_q && !mc_wb_valid);
    if (mc_accept) begin
      mc_busy_d    = 1'b1;
      cnt_d        = CNT_LOAD;
      pending_rd_d = rd_EX;
    end else if (mc_busy_q) begin
      if (mc_wb_valid) begin
        mc_busy_d = 1'b0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_busy_q    <= 1'b0;
      cnt_q        <= '0;
      pending_rd_q <= '0;
      mc_err_q     <= 1'b0;
    end else begin
      mc_busy_q    <= mc_busy_d;
      cnt_q        <= cnt_d;
      pending_rd_q <= pending_rd_d;
      mc_err_q     <= mc_err_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d, mc_stall_cnt_q, mc_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    mc_stall_cnt_d = mc_stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (mc_cause && (mc_stall_cnt_q != '1))
      mc_stall_cnt_d = mc_stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      mc_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      mc_stall_cnt_q <= mc_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign mc_stall_cnt = mc_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed vectors, one per clock cycle. The stimulus process drives the
// inputs just after each rising edge and pushes the hand-computed expected
// outputs into a queue. The monitor pops one entry on each falling edge and
// compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS*AW-1:0] rs_ID, rs_EX;
  logic [AW-1:0] rd_ID, rd_EX, rd_MEM, rd_WB;
  logic          regWrite_ID, branch_ID, mc_ID, regWrite_EX, memRead_EX, mc_issue;
  logic          regWrite_MEM, regWrite_WB, memRead_MEM;
  logic          stall, mc_busy, mc_wb_valid, mc_err;
  logic [NS-1:0] BJSel;
  logic [NS*2-1:0] ExSel;
  logic [AW-1:0] mc_wb_rd;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   stall_cnt, mc_stall_cnt;
`endif

  hazard_forward_unit #(.AW(AW), .NUM_SRC(NS), .MC_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_ID(rs_ID), .rd_ID(rd_ID), .regWrite_ID(regWrite_ID),
    .branch_ID(branch_ID), .mc_ID(mc_ID),
    .rs_EX(rs_EX), .rd_EX(rd_EX), .regWrite_EX(regWrite_EX),
    .memRead_EX(memRead_EX), .mc_issue(mc_issue),
    .rd_MEM(rd_MEM), .rd_WB(rd_WB),
    .regWrite_MEM(regWrite_MEM), .regWrite_WB(regWrite_WB),
    .memRead_MEM(memRead_MEM),
    .stall(stall), .BJSel(BJSel), .ExSel(ExSel),
    .mc_busy(mc_busy), .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd),
    .mc_err(mc_err)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .mc_stall_cnt(mc_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic [1:0]  bj;
    logic [3:0]  ex;
    logic        busy;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        err;
    logic        pz;    // performance counters expected at zero
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string f, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
    end
  endtask

  // Monitor: one comparison set per cycle in which a vector is outstanding.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "stall", 32'(stall), 32'(e.stall));
        chk(e.name, "BJSel", 32'(BJSel), 32'(e.bj));
        chk(e.name, "ExSel", 32'(ExSel), 32'(e.ex));
        chk(e.name, "mc_busy", 32'(mc_busy), 32'(e.busy));
        chk(e.name, "mc_wb_valid", 32'(mc_wb_valid), 32'(e.wbv));
        if (e.wbv) chk(e.name, "mc_wb_rd", 32'(mc_wb_rd), 32'(e.wbrd));
        chk(e.name, "mc_err", 32'(mc_err), 32'(e.err));
`ifdef HAZ_PERF_CNT_EN
        if (e.pz) begin
          chk(e.name, "stall_cnt", stall_cnt, 32'd0);
          chk(e.name, "mc_stall_cnt", mc_stall_cnt, 32'd0);
        end
`endif
        $display("VEC %-10s stall=%0b BJSel=%b ExSel=%b busy=%0b wbv=%0b wbrd=%0d err=%0b",
                 e.name, stall, BJSel, ExSel, mc_busy, mc_wb_valid, mc_wb_rd, mc_err);
      end
    end
  end

  task automatic idle();
    rs_ID = '0; rd_ID = '0; regWrite_ID = 0; branch_ID = 0; mc_ID = 0;
    rs_EX = '0; rd_EX = '0; regWrite_EX = 0; memRead_EX = 0; mc_issue = 0;
    rd_MEM = '0; rd_WB = '0; regWrite_MEM = 0; regWrite_WB = 0; memRead_MEM = 0;
  endtask

  // Advance one cycle and return all inputs to the idle pipeline state.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_v(input string nm, input logic st, input logic [1:0] bj,
                          input logic [3:0] ex, input logic busy, input logic wbv,
                          input logic [4:0] wbrd, input logic err,
                          input logic pz = 1'b0);
    exp_t e;
    e.name = nm; e.stall = st; e.bj = bj; e.ex = ex; e.busy = busy;
    e.wbv = wbv; e.wbrd = wbrd; e.err = err; e.pz = pz;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset state
    step();                 expect_v("rst_hold", 0, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
    step(); rst_n = 1'b1;   expect_v("rst_rel",  0, 2'b00, 4'b0000, 0, 0, 0, 0, 1);

    // ALU forwarding chain
    step(); rd_MEM = 5; regWrite_MEM = 1; rd_WB = 5; regWrite_WB = 1; rs_EX[4:0] = 5;
            expect_v("alu_mem", 0, 2'b00, 4'b0001, 0, 0, 0, 0);
    step(); rd_MEM = 5; rd_WB = 5; regWrite_WB = 1; rs_EX[4:0] = 5;
            expect_v("alu_wb", 0, 2'b00, 4'b0010, 0, 0, 0, 0);
    step(); regWrite_MEM = 1; regWrite_WB = 1;
            expect_v("alu_x0", 0, 2'b00, 4'b0000, 0, 0, 0, 0);
    step(); rd_MEM = 6; regWrite_MEM = 1; rd_WB = 5; regWrite_WB = 1;
            rs_EX[4:0] = 5; rs_EX[9:5] = 6; rs_ID[4:0] = 6;
            expect_v("alu_mix", 0, 2'b01, 4'b0110, 0, 0, 0, 0);
    step(); rd_MEM = 6; regWrite_MEM = 1; memRead_MEM = 1; rd_WB = 5; regWrite_WB = 1;
            rs_EX[4:0] = 5; rs_EX[9:5] = 6; rs_ID[4:0] = 6;
            expect_v("bj_load", 0, 2'b00, 4'b0110, 0, 0, 0, 0);

    // Load-use
    step(); memRead_EX = 1; rd_EX = 7; regWrite_EX = 1; rs_ID[9:5] = 7;
            expect_v("ld_use", 1, 2'b00, 4'b0000, 0, 0, 0, 0);
    step(); rd_WB = 7; regWrite_WB = 1; rs_EX[9:5] = 7;
            expect_v("ld_fwd", 0, 2'b00, 4'b1000, 0, 0, 0, 0);
    step(); memRead_EX = 1; rd_EX = 0; regWrite_EX = 1;
            expect_v("ld_x0", 0, 2'b00, 4'b0000, 0, 0, 0, 0);

    // Branch after load: two stall cycles, then released
    step(); branch_ID = 1; rs_ID[4:0] = 3; memRead_EX = 1; rd_EX = 3; regWrite_EX = 1;
            expect_v("br_ld1", 1, 2'b00, 4'b0000, 0, 0, 0, 0);
    step(); branch_ID = 1; rs_ID[4:0] = 3; memRead_MEM = 1; rd_MEM = 3; regWrite_MEM = 1;
            expect_v("br_ld2", 1, 2'b00, 4'b0000, 0, 0, 0, 0);
    step(); branch_ID = 1; rs_ID[4:0] = 3; rd_WB = 3; regWrite_WB = 1;
            expect_v("br_ld3", 0, 2'b00, 4'b0000, 0, 0, 0, 0);

    // Branch after ALU: one stall, then MEM forward
    step(); branch_ID = 1; rs_ID[9:5] = 4; rd_EX = 4; regWrite_EX = 1;
            expect_v("br_alu1", 1, 2'b00, 4'b0000, 0, 0, 0, 0);
    step(); branch_ID = 1; rs_ID[9:5] = 4; rd_MEM = 4; regWrite_MEM = 1;
            expect_v("br_alu2", 0, 2'b10, 4'b0000, 0, 0, 0, 0);

    // Multi-cycle RAW: issue at t, completion at t+3
    step(); mc_issue = 1; rd_EX = 9; regWrite_EX = 1; rs_ID[4:0] = 9;
            expect_v("mc_t0", 1, 2'b00, 4'b0000, 0, 0, 0, 0);
    step(); rs_ID[4:0] = 9;
            expect_v("mc_t1", 1, 2'b00, 4'b0000, 1, 0, 0, 0);
    step(); rs_ID[4:0] = 9;
            expect_v("mc_t2", 1, 2'b00, 4'b0000, 1, 0, 0, 0);
    step(); rs_ID[4:0] = 9; rs_EX[4:0] = 9;
            expect_v("mc_t3", 0, 2'b00, 4'b0011, 1, 1, 9, 0);
    step(); rs_EX[4:0] = 9;
            expect_v("mc_t4", 0, 2'b00, 4'b0000, 0, 0, 0, 0);

    // Structural stall and ignored issue while busy
    step(); mc_issue = 1; rd_EX = 10; regWrite_EX = 1; mc_ID = 1;
            expect_v("st_u0", 1, 2'b00, 4'b0000, 0, 0, 0, 0);
    step(); mc_ID = 1; mc_issue = 1; rd_EX = 11; regWrite_EX = 1;
            expect_v("st_u1", 1, 2'b00, 4'b0000, 1, 0, 0, 0);
    step(); mc_ID = 1;
            expect_v("st_u2", 1, 2'b00, 4'b0000, 1, 0, 0, 1);
    step(); mc_ID = 1;
            expect_v("st_u3", 0, 2'b00, 4'b0000, 1, 1, 10, 1);
    step(); mc_issue = 1; rd_EX = 12; regWrite_EX = 1;
            expect_v("st_u4", 0, 2'b00, 4'b0000, 0, 0, 0, 1);

    // WAW against the pending destination, then reset mid-operation
    step(); regWrite_ID = 1; rd_ID = 12;
            expect_v("waw_u5", 1, 2'b00, 4'b0000, 1, 0, 0, 1);
    step(); regWrite_ID = 1; rd_ID = 12; rst_n = 1'b0;
            expect_v("rst_mid", 0, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
    step(); rst_n = 1'b1;
            expect_v("rst_mid2", 0, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
    step(); expect_v("rst_post1", 0, 2'b00, 4'b0000, 0, 0, 0, 0);
    step(); expect_v("rst_post2", 0, 2'b00, 4'b0000, 0, 0, 0, 0);

    // Drain: the monitor must consume every expected entry.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    chk("drain", "queue_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
